// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game constants: colour widths, colours, layer indices, flash length
package game_pkg;

    localparam int DEF_RGB_IN_W     = 3;
    localparam int DEF_OUT_W        = 4;
    localparam int DEF_FLASH_FRAMES = 30;

    // Colours are {r,g,b}, one bit per channel.
    localparam logic [2:0] BLACK   = 3'b000;
    localparam logic [2:0] BLUE    = 3'b001;
    localparam logic [2:0] GREEN   = 3'b010;
    localparam logic [2:0] CYAN    = 3'b011;
    localparam logic [2:0] RED     = 3'b100;
    localparam logic [2:0] MAGENTA = 3'b101;
    localparam logic [2:0] YELLOW  = 3'b110;
    localparam logic [2:0] WHITE   = 3'b111;

    localparam int LAYER_USER     = 0;
    localparam int LAYER_BULLET   = 1;
    localparam int LAYER_SPIDER   = 2;
    localparam int LAYER_MOSQUITO = 3;
    localparam int LAYER_FLY      = 4;

endpackage

// File: rtl/layer_flash_timer.sv
// rtl/layer_flash_timer.sv - per-layer hit-flash frame counter with blink-hide output
// Ports: clk25/reset (sync, active-high); load restarts the count at FLASH_FRAMES;
// frame_tick decrements a nonzero count; hide is high on odd nonzero counts;
// active is high while the count is nonzero.
module layer_flash_timer
    import game_pkg::*;
#(
    parameter int FLASH_FRAMES = DEF_FLASH_FRAMES
) (
    input  logic clk25,
    input  logic reset,
    input  logic load,
    input  logic frame_tick,
    output logic hide,
    output logic active
);

    localparam int CNT_W = $clog2(FLASH_FRAMES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A load on a frame-tick cycle wins; the tick is dropped that cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CNT_W'(FLASH_FRAMES);
        end else if (frame_tick && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk25) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign active = (cnt_q != '0);
    assign hide   = active & cnt_q[0];

endmodule

// File: rtl/layer_compositor.sv
// rtl/layer_compositor.sv - priority sprite-layer compositor with flash blink and player collision
// Ports: clk25/reset (sync, active-high); layer_rgb_flat/layer_valid/layer_en per layer;
// flash_req per-layer flash start pulse; video_on/hsync_in/vsync_in from the VGA timing;
// vga_r/g/b, hsync, vsync two cycles later; frame_pulse after each vsync falling edge;
// collide_frame = player overlaps seen in the previous frame; flashing = per-layer flash active.
module layer_compositor
    import game_pkg::*;
#(
    parameter int                  LAYER_COUNT  = 6,
    parameter int                  RGB_IN_W     = DEF_RGB_IN_W,
    parameter int                  OUT_W        = DEF_OUT_W,
    parameter int                  FLASH_FRAMES = DEF_FLASH_FRAMES,
    parameter logic [RGB_IN_W-1:0] BG_RGB       = 3'b000
) (
    input  logic                            clk25,
    input  logic                            reset,
    input  logic [LAYER_COUNT*RGB_IN_W-1:0] layer_rgb_flat,
    input  logic [LAYER_COUNT-1:0]          layer_valid,
    input  logic [LAYER_COUNT-1:0]          layer_en,
    input  logic [LAYER_COUNT-1:0]          flash_req,
    input  logic                            video_on,
    input  logic                            hsync_in,
    input  logic                            vsync_in,
    output logic [OUT_W-1:0]                vga_r,
    output logic [OUT_W-1:0]                vga_g,
    output logic [OUT_W-1:0]                vga_b,
    output logic                            hsync,
    output logic                            vsync,
    output logic                            frame_pulse,
    output logic [LAYER_COUNT-1:0]          collide_frame,
    output logic [LAYER_COUNT-1:0]          flashing
);

    logic [LAYER_COUNT-1:0] flash_hide;
    logic [LAYER_COUNT-1:0] vis;
    logic [LAYER_COUNT-1:0] hits;
    logic                   frame_bnd;

    // Stage 1
    logic [RGB_IN_W-1:0] rgb1_q, rgb1_d;
    logic                video_on1_q, hsync1_q, vsync1_q;
    // Stage 2
    logic [OUT_W-1:0]    vga_r_q, vga_g_q, vga_b_q;
    logic [OUT_W-1:0]    vga_r_d, vga_g_d, vga_b_d;
    logic                hsync2_q, vsync2_q;
    // Frame bookkeeping
    logic                   frame_pulse_q;
    logic [LAYER_COUNT-1:0] acc_q, acc_d;
    logic [LAYER_COUNT-1:0] collide_q, collide_d;

    // The stage-1 vsync copy doubles as the previous-cycle vsync_in.
    assign frame_bnd = ~vsync_in & vsync1_q;

    for (genvar i = 0; i < LAYER_COUNT; i++) begin : g_flash
        layer_flash_timer #(
            .FLASH_FRAMES (FLASH_FRAMES)
        ) u_timer (
            .clk25      (clk25),
            .reset      (reset),
            .load       (flash_req[i]),
            .frame_tick (frame_bnd),
            .hide       (flash_hide[i]),
            .active     (flashing[i])
        );
    end

    assign vis = layer_valid & layer_en & ~flash_hide;

    // Walk from the lowest priority upward so the lowest visible index wins.
    always_comb begin
        rgb1_d = BG_RGB;
        for (int i = LAYER_COUNT - 1; i >= 0; i--) begin
            if (vis[i]) begin
                rgb1_d = layer_rgb_flat[i*RGB_IN_W +: RGB_IN_W];
            end
        end
    end

    always_comb begin
        vga_r_d = video_on1_q ? {OUT_W{rgb1_q[2]}} : '0;
        vga_g_d = video_on1_q ? {OUT_W{rgb1_q[1]}} : '0;
        vga_b_d = video_on1_q ? {OUT_W{rgb1_q[0]}} : '0;
    end

    // Collision uses raw valid so a blinking layer still registers hits;
    // bit 0 is masked since the player cannot collide with itself.
    assign hits = {LAYER_COUNT{video_on & layer_valid[0] & layer_en[0]}}
                & layer_valid & layer_en & ~LAYER_COUNT'(1);

    // On a boundary the finished frame is published and the new frame starts
    // from this cycle's hits, so nothing is lost or counted twice.
    always_comb begin
        acc_d     = acc_q | hits;
        collide_d = collide_q;
        if (frame_bnd) begin
            acc_d     = hits;
            collide_d = acc_q;
        end
    end

    always_ff @(posedge clk25) begin
        if (reset) begin
            rgb1_q        <= '0;
            video_on1_q   <= 1'b0;
            hsync1_q      <= 1'b1;
            vsync1_q      <= 1'b1;
            vga_r_q       <= '0;
            vga_g_q       <= '0;
            vga_b_q       <= '0;
            hsync2_q      <= 1'b1;
            vsync2_q      <= 1'b1;
            frame_pulse_q <= 1'b0;
            acc_q         <= '0;
            collide_q     <= '0;
        end else begin
            rgb1_q        <= rgb1_d;
            video_on1_q   <= video_on;
            hsync1_q      <= hsync_in;
            vsync1_q      <= vsync_in;
            vga_r_q       <= vga_r_d;
            vga_g_q       <= vga_g_d;
            vga_b_q       <= vga_b_d;
            hsync2_q      <= hsync1_q;
            vsync2_q      <= vsync1_q;
            frame_pulse_q <= frame_bnd;
            acc_q         <= acc_d;
            collide_q     <= collide_d;
        end
    end

    assign vga_r         = vga_r_q;
    assign vga_g         = vga_g_q;
    assign vga_b         = vga_b_q;
    assign hsync         = hsync2_q;
    assign vsync         = vsync2_q;
    assign frame_pulse   = frame_pulse_q;
    assign collide_frame = collide_q;

endmodule

// File: tb/tb_layer_compositor.sv
// tb/tb_layer_compositor.sv - scoreboard bench for layer_compositor against a behavioural model
module tb_layer_compositor;

    localparam int NL  = 6;
    localparam int FF  = 4;
    localparam int FLEN = 48;

    logic              clk25 = 1'b0;
    logic              reset;
    logic [NL*3-1:0]   layer_rgb_flat;
    logic [NL-1:0]     layer_valid, layer_en, flash_req;
    logic              video_on, hsync_in, vsync_in;
    logic [3:0]        vga_r, vga_g, vga_b;
    logic              hsync, vsync, frame_pulse;
    logic [NL-1:0]     collide_frame, flashing;

    layer_compositor #(
        .LAYER_COUNT  (NL),
        .FLASH_FRAMES (FF)
    ) dut (
        .clk25          (clk25),
        .reset          (reset),
        .layer_rgb_flat (layer_rgb_flat),
        .layer_valid    (layer_valid),
        .layer_en       (layer_en),
        .flash_req      (flash_req),
        .video_on       (video_on),
        .hsync_in       (hsync_in),
        .vsync_in       (vsync_in),
        .vga_r          (vga_r),
        .vga_g          (vga_g),
        .vga_b          (vga_b),
        .hsync          (hsync),
        .vsync          (vsync),
        .frame_pulse    (frame_pulse),
        .collide_frame  (collide_frame),
        .flashing       (flashing)
    );

    always #20 clk25 = ~clk25;

    typedef struct {
        int          due;
        logic [15:0] val;
    } exp_t;

    exp_t vq[$];
    exp_t sq[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk25) cyc <= cyc + 1;

    // Reference state: flash frames remaining, collision set for the current
    // frame, the last published collision set, and the last vsync level seen.
    int       cnt[NL];
    bit [5:0] acc_m, coll_m;
    bit       prev_vs;

    function automatic logic [15:0] pix(input bit vid, input bit [2:0] c, input bit hs, input bit vs);
        logic [3:0] r, g, b;
        r = vid ? {4{c[2]}} : 4'h0;
        g = vid ? {4{c[1]}} : 4'h0;
        b = vid ? {4{c[0]}} : 4'h0;
        return {2'b00, r, g, b, hs, vs};
    endfunction

    task automatic step(input bit rst, input bit vid, input bit hs, input bit vs,
                        input bit [5:0] valid, input bit [5:0] en, input bit [5:0] freq,
                        input bit [17:0] rgb);
        exp_t     e;
        bit [2:0] col;
        bit [5:0] hit, flag;
        bit       bnd;
        @(posedge clk25);
        #1;
        reset = rst; video_on = vid; hsync_in = hs; vsync_in = vs;
        layer_valid = valid; layer_en = en; flash_req = freq; layer_rgb_flat = rgb;

        if (rst) begin
            e.due = cyc + 2; e.val = pix(1'b0, 3'b000, 1'b1, 1'b1); vq.push_back(e);
            // The output register is cleared too, replacing the pixel due next.
            foreach (vq[k]) if (vq[k].due == cyc + 1) vq[k].val = pix(1'b0, 3'b000, 1'b1, 1'b1);
            foreach (cnt[i]) cnt[i] = 0;
            acc_m = '0; coll_m = '0; prev_vs = 1'b1;
            e.due = cyc + 1; e.val = '0; sq.push_back(e);
            return;
        end

        col = 3'b000;
        for (int i = NL - 1; i >= 0; i--)
            if (valid[i] && en[i] && (cnt[i] % 2 == 0)) col = rgb[i*3 +: 3];
        e.due = cyc + 2; e.val = pix(vid, col, hs, vs); vq.push_back(e);

        bnd = !vs && prev_vs;
        for (int i = 0; i < NL; i++) begin
            if (freq[i]) cnt[i] = FF;
            else if (bnd && cnt[i] > 0) cnt[i] = cnt[i] - 1;
        end
        hit = '0;
        if (vid && valid[0] && en[0])
            for (int j = 1; j < NL; j++) hit[j] = valid[j] & en[j];
        if (bnd) begin coll_m = acc_m; acc_m = hit; end
        else acc_m = acc_m | hit;
        prev_vs = vs;
        for (int i = 0; i < NL; i++) flag[i] = (cnt[i] != 0);
        e.due = cyc + 1; e.val = {3'b000, bnd, coll_m, flag}; sq.push_back(e);
    endtask

    always @(negedge clk25) begin
        logic [15:0] got;
        while (vq.size() > 0 && vq[0].due <= cyc) begin
            got = {2'b00, vga_r, vga_g, vga_b, hsync, vsync};
            n_checks++;
            if (vq[0].due != cyc || got !== vq[0].val) begin
                n_fail++;
                $display("FAIL video cyc=%0d due=%0d got=%h exp=%h", cyc, vq[0].due, got, vq[0].val);
            end
            void'(vq.pop_front());
        end
        while (sq.size() > 0 && sq[0].due <= cyc) begin
            got = {3'b000, frame_pulse, collide_frame, flashing};
            n_checks++;
            if (sq[0].due != cyc || got !== sq[0].val) begin
                n_fail++;
                $display("FAIL status cyc=%0d due=%0d got=%h exp=%h", cyc, sq[0].due, got, sq[0].val);
            end
            void'(sq.pop_front());
        end
    end

    initial begin
        bit [5:0] en, freq, valid;
        bit       vid, hs, vs;

        reset = 1'b1; video_on = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
        layer_valid = '0; layer_en = '0; flash_req = '0; layer_rgb_flat = '0;
        foreach (cnt[i]) cnt[i] = 0;
        acc_m = '0; coll_m = '0; prev_vs = 1'b1;

        // Reset with a held flash request: reset must dominate.
        for (int k = 0; k < 3; k++) step(1, 0, 1, 1, '0, '1, 6'b000100, '0);

        // Directed priority: layers 0/2/4 -> red, then layer 0 disabled -> green.
        step(0, 1, 1, 1, 6'b010101, 6'b111111, 0, {3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100});
        step(0, 1, 1, 1, 6'b010101, 6'b111110, 0, {3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100});
        step(0, 0, 1, 1, 6'b000010, 6'b111111, 0, {15'h0, 3'b111});

        // Long hsync pulse with blanking, sync alignment across 96 cycles.
        for (int t = 0; t < 120; t++)
            step(0, (t % 3) != 0, !(t >= 10 && t < 106), 1, 6'($urandom), 6'h3F, 0, 18'($urandom));

        // Randomised frames with flashes, overlaps, enable masks and a mid-frame reset.
        for (int f = 0; f < 30; f++) begin
            en = (f % 4 == 3) ? 6'($urandom) : 6'h3F;
            for (int t = 0; t < FLEN; t++) begin
                vs  = !(t < 2);
                hs  = !((t % 16) < 3);
                vid = ((t % 16) >= 5) && t >= 4;
                valid = 6'($urandom) & 6'($urandom_range(0, 63));
                freq = '0;
                if (t == 0 && $urandom_range(0, 3) == 0) freq = 6'(1 << $urandom_range(0, NL - 1));
                else if ($urandom_range(0, 63) == 0) freq = 6'(1 << $urandom_range(0, NL - 1));
                if (f == 12 && t == 20) step(1, vid, hs, vs, valid, en, 6'b000110, 18'($urandom));
                else step(0, vid, hs, vs, valid, en, freq, 18'($urandom));
            end
        end

        for (int k = 0; k < 4; k++) step(0, 0, 1, 1, '0, '0, '0, '0);
        repeat (3) @(posedge clk25);
        #2;
        n_checks++;
        if (vq.size() != 0 || sq.size() != 0) begin
            n_fail++;
            $display("FAIL drain got=%0d/%0d pending exp=0/0", vq.size(), sq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/layer_compositor.md
Name: layer_compositor

Overview:
- Parametrised successor to the fixed-priority user/bullet/enemy colour mux in the game top level.
- Merges LAYER_COUNT sprite layers into the VGA RGB stream using index priority (layer 0 highest) and a per-layer enable mask.
- Adds per-layer hit-flash blinking, per-frame collision detection of layer 0 (player) against every other layer, and a 2-cycle registered pipeline with aligned sync outputs.
- Sits between the sprite drawers / vga_controller and the board VGA pins.

Parameters:
- LAYER_COUNT, 6: number of layers; index 0 is the player layer and has highest priority.
- RGB_IN_W, 3: colour bits per layer, ordered {r,g,b}, 1 bit each.
- OUT_W, 4: output bits per channel; each input bit is replicated OUT_W times.
- FLASH_FRAMES, 30: frames a flash lasts after a flash request.
- BG_RGB, 3'b000: colour shown when no enabled, visible layer is valid.

Ports:
- clk25, input, 1: 25 MHz pixel clock.
- reset, input, 1: synchronous, active-high.
- layer_rgb_flat, input, LAYER_COUNT*RGB_IN_W: layer i colour at [i*RGB_IN_W +: RGB_IN_W].
- layer_valid, input, LAYER_COUNT: layer i covers the current pixel.
- layer_en, input, LAYER_COUNT: 0 removes the layer from display and from collision.
- flash_req, input, LAYER_COUNT: 1-cycle pulse that starts or restarts the flash on layer i.
- video_on, input, 1: from vga_controller.
- hsync_in, input, 1: from vga_controller; active-low.
- vsync_in, input, 1: from vga_controller; active-low.
- vga_r, vga_g, vga_b, output, OUT_W each: pixel colour.
- hsync, vsync, output, 1 each: syncs delayed to match the colour pipeline.
- frame_pulse, output, 1: 1-cycle pulse at each frame boundary.
- collide_frame, output, LAYER_COUNT: bit j = layer 0 overlapped layer j during the previous frame; bit 0 is always 0.
- flashing, output, LAYER_COUNT: layer i flash counter is nonzero.

Behaviour:
- Reset values: vga_* = 0, hsync = 1, vsync = 1, frame_pulse = 0, collide_frame = 0, flashing = 0, all flash counters = 0, collision accumulator = 0, both pipeline stages cleared (stage-1 syncs = 1).
- Frame boundary: the cycle where vsync_in is 0 and the registered previous vsync_in is 1 (falling edge). frame_pulse is asserted on the cycle after that.
- Visibility: vis[i] = layer_valid[i] & layer_en[i] & ~(flash_cnt[i] != 0 & flash_cnt[i][0]). A flashing layer is hidden on odd counter values, so it blinks every frame.
- Stage 1 (registered):
  - sel = lowest i with vis[i]; rgb1 = that layer's colour, or BG_RGB if none.
  - Register video_on, hsync_in and vsync_in alongside rgb1.
- Stage 2 (registered):
  - vga_x = video_on1 ? {OUT_W{rgb1 bit}} : 0.
  - hsync/vsync = stage-1 copies.
- Latency is exactly 2 clk25 cycles from inputs to vga_*/hsync/vsync for every pixel.
- Flash counter per layer, width $clog2(FLASH_FRAMES+1):
  - flash_req[i] loads FLASH_FRAMES.
  - Otherwise the counter decrements by 1 at each frame boundary while nonzero, and saturates at 0.
  - flash_req on a frame-boundary cycle: the load wins and there is no decrement that cycle.
  - flash_req while already flashing restarts the count at FLASH_FRAMES.
- Collision accumulator:
  - Each cycle with video_on & layer_valid[0] & layer_en[0], set acc[j] |= layer_valid[j] & layer_en[j] for j ≥ 1.
  - Collision uses raw valid, so flash hiding does not suppress it.
  - On a frame-boundary cycle: collide_frame <= acc; acc <= that cycle's hits only, with no loss and no double count.
  - collide_frame holds for the whole following frame.
- Reset mid-frame: all state is cleared. The first collide_frame after reset reflects only post-reset pixels.
- Width rules: LAYER_COUNT 1..16. With LAYER_COUNT = 1, collide_frame is constant 0.

Decomposition:
- Shared package `game_pkg`:
  - RGB_IN_W and OUT_W defaults.
  - Colour constants (BLACK, WHITE, RED, ...).
  - Layer index constants: LAYER_USER = 0, LAYER_BULLET = 1, LAYER_SPIDER = 2, LAYER_MOSQUITO = 3, LAYER_FLY = 4.
  - FLASH_FRAMES default.
- One sub-module, `layer_flash_timer`: a single layer's counter with load, frame tick and a blink-hide output, generated LAYER_COUNT times.
- Priority resolution and collision logic stay inline.

Test Plan:
- Priority and latency: layers 0, 2 and 4 valid with colours 3'b100, 3'b010, 3'b001, all enabled → 2 cycles later vga_r = 4'hF, vga_g = 0, vga_b = 0. Set layer_en[0] = 0 → vga_g = 4'hF after 2 cycles.
- Blanking and sync alignment: video_on = 0 with layer 1 valid → vga_* = 0. An hsync_in low pulse of 96 cycles appears on hsync delayed exactly 2 cycles with the same width.
- Flash: pulse flash_req[1] with FLASH_FRAMES = 4 → layer 1 hidden in frames 1 and 3 and shown in frames 2 and 4 (counter 3 and 1 odd, 2 even); flashing[1] clears after the 4th boundary.
  - A second flash_req on the boundary cycle reloads the counter to 4.
- Collision: layers 0 and 3 overlap for 10 pixels in frame N → collide_frame = 6'b001000 after boundary N→N+1, then 0 after N+1→N+2 if there is no overlap.
  - An overlap where layer_en[3] = 0 leaves collide_frame = 0.
- Reset mid-frame: assert reset for 1 cycle during an active flash and an accumulated collision → next cycle flashing = 0, vga_* = 0, hsync = 1, and collide_frame = 0 at the next boundary.
- Reset and flash collision: flash_req[2] held with reset high → counter stays 0 (reset dominates).
